// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// Funct codes and ALUOp/ALUControl values.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_BNE     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath-control outputs of the multicycle controller.
interface multicycle_controller_if #(
   parameter int unsigned STATE_W = 4
);
   logic [5:0]         Opcode;
   logic [5:0]         Funct;
   logic               Zero;
   logic               MemReady;
   logic               IorD;
   logic               IRWrite;
   logic               MemWrite;
   logic               RegDst;
   logic               MemtoReg;
   logic               RegWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         PCSrc;
   logic [2:0]         ALUControl;
   logic               PCEn;
   logic [STATE_W-1:0] State;

   modport master (
      output Opcode, Funct, Zero, MemReady,
      input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
      input  ALUSrcB, PCSrc, ALUControl, PCEn, State
   );

   modport slave (
      input  Opcode, Funct, Zero, MemReady,
      output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
      output ALUSrcB, PCSrc, ALUControl, PCEn, State
   );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational ALUOp/Funct -> ALUControl decode.
module alu_op_decoder
   import mc_pkg::*;
(
   input  aluop_t     alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FN_ADD:  alu_control_o = ALU_ADD;
               FN_SUB:  alu_control_o = ALU_SUB;
               FN_AND:  alu_control_o = ALU_AND;
               FN_OR:   alu_control_o = ALU_OR;
               FN_SLT:  alu_control_o = ALU_SLT;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for a multicycle MIPS-style datapath.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input logic                   clk,
   input logic                   reset,
   multicycle_controller_if.slave bus
);

   state_t     state_q, state_d;
   aluop_t     alu_op;
   logic       valid_state;
   logic [2:0] alu_control;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = S_FETCH;
      valid_state  = 1'b1;
      alu_op       = ALUOP_ADD;
      bus.IorD     = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegDst   = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.RegWrite = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.PCSrc    = 2'b00;
      bus.PCEn     = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = bus.MemReady;
            bus.PCEn    = bus.MemReady;
            state_d     = bus.MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            bus.ALUSrcB = 2'b11;
            // Unrecognised opcodes fall back to FETCH and retire as a NOP.
            case (bus.Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
               OP_BNE:       state_d = S_BNE;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            state_d     = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            bus.IorD = 1'b1;
            state_d  = bus.MemReady ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_MEMWR: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
            state_d      = bus.MemReady ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            bus.ALUSrcA = 1'b1;
            alu_op      = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_ADDIEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: bus.RegWrite = 1'b1;
         S_BEQ: begin
            bus.ALUSrcA = 1'b1;
            bus.PCSrc   = 2'b01;
            bus.PCEn    = bus.Zero;
            alu_op      = ALUOP_SUB;
         end
`ifdef MULTICYCLE_BNE_EN
         S_BNE: begin
            bus.ALUSrcA = 1'b1;
            bus.PCSrc   = 2'b01;
            bus.PCEn    = ~bus.Zero;
            alu_op      = ALUOP_SUB;
         end
`endif
         S_JUMP: begin
            bus.PCSrc = 2'b10;
            bus.PCEn  = 1'b1;
         end
         default: valid_state = 1'b0;
      endcase
   end

   alu_op_decoder u_alu_op_decoder (
      .alu_op_i      (alu_op),
      .funct_i       (bus.Funct),
      .alu_control_o (alu_control)
   );

   // Unused state codes must present an all-zero control word, ALUControl included.
   assign bus.ALUControl = valid_state ? alu_control : '0;
   assign bus.State      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, directed
// corner sequences and randomized instruction streams against a path model.
module tb_multicycle_controller;

   typedef struct packed {
      logic       IorD;
      logic       IRWrite;
      logic       MemWrite;
      logic       RegDst;
      logic       MemtoReg;
      logic       RegWrite;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [1:0] PCSrc;
      logic [2:0] ALUControl;
      logic       PCEn;
   } ctl_t;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      int unsigned cycles;
      logic [2:0]  alu3;
      logic [2:0]  wb;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   multicycle_controller_if #(.STATE_W(4)) bus ();

   multicycle_controller #(.STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ctl_t act;
   assign act = {bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegDst, bus.MemtoReg,
                 bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUControl, bus.PCEn};

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, a, e, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr);
      bus.Opcode   = op;
      bus.Funct    = fn;
      bus.Zero     = z;
      bus.MemReady = mr;
   endtask

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic ctl_t exp_out(input int unsigned st, input logic mr, input logic z,
                                    input logic [5:0] f);
      ctl_t c;
      c = '0;
      c.ALUControl = 3'b010;
      case (st)
         0: begin c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCEn = mr; end
         1: c.ALUSrcB = 2'b11;
         2, 9: begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
         3: c.IorD = 1'b1;
         4: begin c.MemtoReg = 1'b1; c.RegWrite = 1'b1; end
         5: begin c.IorD = 1'b1; c.MemWrite = 1'b1; end
         6: begin c.ALUSrcA = 1'b1; c.ALUControl = funct_alu(f); end
         7: begin c.RegDst = 1'b1; c.RegWrite = 1'b1; end
         8: begin c.ALUSrcA = 1'b1; c.PCSrc = 2'b01; c.ALUControl = 3'b110; c.PCEn = z; end
         10: c.RegWrite = 1'b1;
         11: begin c.PCSrc = 2'b10; c.PCEn = 1'b1; end
         12: begin c.ALUSrcA = 1'b1; c.PCSrc = 2'b01; c.ALUControl = 3'b110; c.PCEn = ~z; end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Instruction length in cycles with no stalls.
   function automatic int unsigned path_len(input logic [5:0] op);
      case (op)
         6'b100011: return 5;
         6'b101011, 6'b000000, 6'b001000: return 4;
         6'b000100, 6'b000010: return 3;
`ifdef MULTICYCLE_BNE_EN
         6'b000101: return 3;
`endif
         default: return 2;
      endcase
   endfunction

   function automatic int unsigned path_at(input logic [5:0] op, input int unsigned idx);
      int unsigned p[5];
      p = '{0, 1, 0, 0, 0};
      case (op)
         6'b100011: p = '{0, 1, 2, 3, 4};
         6'b101011: p = '{0, 1, 2, 5, 0};
         6'b000000: p = '{0, 1, 6, 7, 0};
         6'b000100: p = '{0, 1, 8, 0, 0};
         6'b001000: p = '{0, 1, 9, 10, 0};
         6'b000010: p = '{0, 1, 11, 0, 0};
`ifdef MULTICYCLE_BNE_EN
         6'b000101: p = '{0, 1, 12, 0, 0};
`endif
         default: ;
      endcase
      return p[idx];
   endfunction

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 8))
         0: return 6'b100011;
         1: return 6'b101011;
         2: return 6'b000000;
         3: return 6'b000100;
         4: return 6'b001000;
         5: return 6'b000010;
         6: return 6'b000101;
         7: return 6'b111111;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [5:0] pick_funct();
      case ($urandom_range(0, 5))
         0: return 6'b100000;
         1: return 6'b100010;
         2: return 6'b100100;
         3: return 6'b100101;
         4: return 6'b101010;
         default: return 6'($urandom);
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v[13];
      int unsigned lw_seq[6];
      int unsigned cnt, mw, idx, st;
      logic [5:0]  rop, rfn;
      logic        rz, rmr;

      v[0]  = '{6'b100011, 6'b000000, 5, 3'b010, 3'b011};
      v[1]  = '{6'b101011, 6'b000000, 4, 3'b010, 3'b000};
      v[2]  = '{6'b000000, 6'b100000, 4, 3'b010, 3'b101};
      v[3]  = '{6'b000000, 6'b100010, 4, 3'b110, 3'b101};
      v[4]  = '{6'b000000, 6'b100100, 4, 3'b000, 3'b101};
      v[5]  = '{6'b000000, 6'b100101, 4, 3'b001, 3'b101};
      v[6]  = '{6'b000000, 6'b101010, 4, 3'b111, 3'b101};
      v[7]  = '{6'b000000, 6'b000111, 4, 3'b010, 3'b101};
      v[8]  = '{6'b000100, 6'b000000, 3, 3'b110, 3'b000};
      v[9]  = '{6'b001000, 6'b000000, 4, 3'b010, 3'b001};
      v[10] = '{6'b000010, 6'b000000, 3, 3'b010, 3'b000};
      v[11] = '{6'b111111, 6'b000000, 2, 3'b010, 3'b000};
`ifdef MULTICYCLE_BNE_EN
      v[12] = '{6'b000101, 6'b000000, 3, 3'b110, 3'b000};
`else
      v[12] = '{6'b000101, 6'b000000, 2, 3'b010, 3'b000};
`endif
      lw_seq = '{0, 1, 2, 3, 4, 0};

      // Reset held: FETCH outputs with IRWrite/PCEn tracking MemReady.
      reset = 1'b1;
      set_in(6'b100011, 6'b0, 1'b0, 1'b0);
      #2;
      chk("reset_state", 32'(bus.State), 32'd0);
      chk("reset_out_mr0", 32'(act), 32'(exp_out(0, 1'b0, 1'b0, 6'b0)));
      bus.MemReady = 1'b1;
      #1;
      chk("reset_out_mr1", 32'(act), 32'(exp_out(0, 1'b1, 1'b0, 6'b0)));
      tick();
      chk("reset_hold_state", 32'(bus.State), 32'd0);
      reset = 1'b0;
      #1;

      // Vector table: instruction length, third-state ALUControl, final-state write controls.
      for (int i = 0; i < 13; i++) begin
         set_in(v[i].op, v[i].funct, 1'b0, 1'b1);
         #1;
         chk($sformatf("vec%0d_start", i), 32'(bus.State), 32'd0);
         cnt = 0;
         do begin
            tick();
            cnt++;
            if (cnt == 2) chk($sformatf("vec%0d_alu", i), 32'(bus.ALUControl), 32'(v[i].alu3));
            if (cnt == v[i].cycles - 1)
               chk($sformatf("vec%0d_wb", i), 32'({bus.RegDst, bus.MemtoReg, bus.RegWrite}),
                   32'(v[i].wb));
         end while (bus.State != 4'd0 && cnt < 20);
         chk($sformatf("vec%0d_cycles", i), cnt, v[i].cycles);
      end

      // lw with MemReady=1.
      set_in(6'b100011, 6'b0, 1'b0, 1'b1);
      #1;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("lw_state%0d", i), 32'(bus.State), lw_seq[i]);
         chk($sformatf("lw_wr%0d", i), 32'({bus.RegWrite, bus.MemtoReg}), (i == 4) ? 32'd3 : 32'd0);
         if (i < 5) tick();
      end

      // sw with three stalled cycles in MEMWR.
      set_in(6'b101011, 6'b0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      chk("sw_in_memwr", 32'(bus.State), 32'd5);
      mw = 0;
      for (int i = 0; i < 4; i++) begin
         bus.MemReady = (i == 3);
         #1;
         if (bus.MemWrite) mw++;
         tick();
      end
      chk("sw_memwrite_cycles", mw, 32'd4);
      chk("sw_back_fetch", 32'(bus.State), 32'd0);

      // beq taken / not taken.
      for (int z = 1; z >= 0; z--) begin
         set_in(6'b000100, 6'b0, 1'(z), 1'b1);
         tick();
         tick();
         chk($sformatf("beq_z%0d_state", z), 32'(bus.State), 32'd8);
         chk($sformatf("beq_z%0d_pcen", z), 32'(bus.PCEn), 32'(z));
         chk($sformatf("beq_z%0d_pcsrc", z), 32'(bus.PCSrc), 32'd1);
         tick();
      end

`ifdef MULTICYCLE_BNE_EN
      for (int z = 1; z >= 0; z--) begin
         set_in(6'b000101, 6'b0, 1'(z), 1'b1);
         tick();
         tick();
         chk($sformatf("bne_z%0d_state", z), 32'(bus.State), 32'd12);
         chk($sformatf("bne_z%0d_pcen", z), 32'(bus.PCEn), 32'(1 - z));
         chk($sformatf("bne_z%0d_pcsrc", z), 32'(bus.PCSrc), 32'd1);
         tick();
      end
`endif

      // Unknown opcode: 0,1,0 with no writes.
      set_in(6'b111111, 6'b0, 1'b0, 1'b1);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("nop_state%0d", i), 32'(bus.State), (i == 1) ? 32'd1 : 32'd0);
         chk($sformatf("nop_writes%0d", i), 32'({bus.RegWrite, bus.MemWrite}), 32'd0);
         if (i < 2) tick();
      end

      // Reset pulsed while stalled in MEMRD.
      set_in(6'b100011, 6'b0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      bus.MemReady = 1'b0;
      #1;
      chk("rstmid_in_memrd", 32'(bus.State), 32'd3);
      #1;
      reset = 1'b1;
      #1;
      chk("rstmid_async", 32'(bus.State), 32'd0);
      reset = 1'b0;
      #1;
      chk("rstmid_after_mr0", 32'(act), 32'(exp_out(0, 1'b0, 1'b0, 6'b0)));
      bus.MemReady = 1'b1;
      #1;
      chk("rstmid_after_mr1", 32'(act), 32'(exp_out(0, 1'b1, 1'b0, 6'b0)));
      tick();
      chk("rstmid_resume", 32'(bus.State), 32'd1);

      // Randomized instruction stream against the path model.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      idx = 0;
      rop = pick_op();
      rfn = pick_funct();
      for (int n = 0; n < 1500; n++) begin
         st  = path_at(rop, idx);
         rz  = 1'($urandom);
         rmr = ($urandom_range(0, 3) != 0);
         set_in(rop, rfn, rz, rmr);
         #1;
         chk("rand_state", 32'(bus.State), st);
         chk("rand_ctl", 32'(act), 32'(exp_out(st, rmr, rz, rfn)));
         if (!((st == 0 || st == 3 || st == 5) && !rmr)) begin
            idx++;
            if (idx == path_len(rop)) begin
               idx = 0;
               rop = pick_op();
               rfn = pick_funct();
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: STATE_W, default 4, width of the state register and the State debug output.
REQ-002 SHALL have ports:
- clk  input  1  single rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Opcode  input  6  Instr[31:26] from the instruction register
- Funct  input  6  Instr[5:0]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory access complete this cycle
- IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath controls
- ALUSrcB  output  2  00 RegB, 01 const 4, 10 SignImm, 11 SignImm<<2
- PCSrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target
- ALUControl  output  3  ALU operation
- PCEn  output  1  PC register enable
- State  output  STATE_W  current state (debug)

Function
REQ-003 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11; BNE=12 only under REQ-014.
REQ-004 Transitions:
- FETCH->DECODE if MemReady=1, else stay in FETCH.
- DECODE: lw/sw(100011/101011)->MEMADR; R-type(000000)->EXECUTE; beq(000100)->BEQ; addi(001000)->ADDIEX; j(000010)->JUMP; any other opcode->FETCH, executed as a NOP.
- MEMADR: lw->MEMRD; sw->MEMWR.
- MEMRD->MEMWB if MemReady=1, else stay. MEMWR->FETCH if MemReady=1, else stay.
- EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, ALUWB, ADDIWB, BEQ, JUMP->FETCH.
REQ-005 Per-state outputs; any output not listed is 0:
- FETCH: ALUSrcB=01, IRWrite=MemReady.
- DECODE: ALUSrcB=11.
- MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1.
- EXECUTE: ALUSrcA=1.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BEQ: ALUSrcA=1, PCSrc=01.
- JUMP: PCSrc=10.
REQ-006 ALUOp SHALL be internal: 00 in FETCH, DECODE, MEMADR and ADDIEX; 10 in EXECUTE; 01 in BEQ/BNE; 00 elsewhere.
REQ-007 ALUControl decode: ALUOp 00->010; ALUOp 01->110; ALUOp 10 by Funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other->010.
REQ-008 PCEn SHALL be (FETCH & MemReady) | JUMP | (BEQ & Zero), combinational in the current cycle.
REQ-009 Each instruction SHALL take, with MemReady held at 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each cycle of MemReady=0 in a wait state adds exactly one cycle.
REQ-010 State SHALL equal the registered state code, zero-extended to STATE_W.
REQ-011 An unused state code SHALL transition to FETCH on the next clock with all outputs 0.

Reset
REQ-012 Asserting reset SHALL force the state to FETCH immediately, asynchronously, including in the middle of an instruction or a stall.
REQ-013 While reset is held, outputs SHALL be the FETCH values: ALUSrcB=01, with IRWrite and PCEn following MemReady. All other outputs SHALL be 0.

Configuration
REQ-014 Macro MULTICYCLE_BNE_EN:
- Defined: opcode 000101 SHALL go DECODE->BNE. BNE outputs SHALL equal BEQ outputs, and BNE SHALL go to FETCH. PCEn SHALL additionally include the term (BNE & ~Zero).
- Undefined: opcode 000101 SHALL be a NOP and state code 12 SHALL be unused.

Structure
REQ-015 A shared package mc_pkg SHALL hold the state encodings, the opcode constants, the Funct constants, and the ALUOp/ALUControl codes.
REQ-016 The ALUOp/Funct->ALUControl decode SHALL be one combinational sub-module, alu_op_decoder; the FSM and PCEn logic SHALL stay in the top module.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset mid-instruction: reset pulsed while in MEMRD -> State=0 within the same cycle; after release, FETCH outputs as in REQ-013.
- lw, MemReady=1: State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- sw with MemReady=0 for 3 cycles in MEMWR: MemWrite=1 for 4 cycles, then State=0.
- R-type, Funct=101010: in EXECUTE, ALUControl=111; in ALUWB, RegDst=1 and RegWrite=1.
- beq: Zero=1 -> PCEn=1 in BEQ with PCSrc=01; Zero=0 -> PCEn=0. With MULTICYCLE_BNE_EN defined, bne PCEn is the inverse of beq.
- Opcode 111111: State sequence 0,1,0 with RegWrite and MemWrite never asserted.
